// File: rtl/memory_sync_param.sv
// Parametrised single-port data memory that clears itself after reset and has a registered read port.
// Latency: a read sampled on edge N drives dataOut/rdValid after edge N. Writes take effect on their sampling edge.
// Backpressure: none. ready stays low while the clear sweep runs, and rd/wr are ignored until ready is high.
//
// Ports: clk/rst (synchronous, active-high reset); addr/rd/wr/dataIn carry requests from the control unit;
//        dataOut/rdValid carry registered read data and its one-cycle strobe; ready is high once the sweep completes;
//        parErr reports a parity error and is qualified by rdValid.
// Build option: define MEM_PARITY_EN to store an even-parity bit beside each word.
//        Without it, parErr is tied to 0.
module memory_sync_param #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              rdValid,
  output logic              ready,
  output logic              parErr
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // One extra bit keeps the range check correct when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_vld_q, rd_vld_d;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdat;
  logic [MEM_W-1:0]  rd_word;
  logic              addr_ok;

  // Encodes a data word in its stored form. When parity is enabled, the top bit makes the total count of ones even.
  function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign addr_ok = {1'b0, addr} < DEPTH_L;
  assign rd_word = mem[addr];

`ifdef MEM_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    dout_d     = dout_q;
    rd_vld_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdat   = '0;
`ifdef MEM_PARITY_EN
    par_err_d  = 1'b0;
`endif
    case (state_q)
      INIT: begin
        // An all-zero word already has even parity, so the clear data needs no encoding.
        mem_we = 1'b1;
        if (clr_addr_q == LAST_IDX) state_d = RUN;
        else                        clr_addr_d = clr_addr_q + 1'b1;
      end
      default: begin
        if (wr && addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = addr;
          mem_wdat  = enc(dataIn);
        end
        if (rd) begin
          rd_vld_d = 1'b1;
          if (wr) begin
            // Write-through: return the incoming data, not the old word.
            dout_d = dataIn;
          end else if (addr_ok) begin
            dout_d = rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
            par_err_d = ^rd_word;
`endif
          end else begin
            dout_d = '0;
          end
        end
      end
    endcase
    // Reset takes priority over both the sweep and any request on the same edge.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
      dout_q     <= '0;
      rd_vld_q   <= 1'b0;
`ifdef MEM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      dout_q     <= dout_d;
      rd_vld_q   <= rd_vld_d;
`ifdef MEM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // The storage array is never reset directly; the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  assign dataOut = dout_q;
  assign rdValid = rd_vld_q;
  assign ready   = (state_q == RUN);
`ifdef MEM_PARITY_EN
  assign parErr  = par_err_q;
`else
  assign parErr  = 1'b0;
`endif

endmodule
